// File: rtl/ser_sub_4.sv
// Bit-serial subtractor: d = a - b - b_i, LSB-first, one full-subtractor cell per clock.
// Define SER_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module ser_sub_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_o,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_o_q, b_o_d;

  logic             diff;
  logic             br_nxt;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] sr_shift;

  // Full-subtractor cell working on the current LSBs.
  assign diff     = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_nxt   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sr_shift = {diff, sr_q[WIDTH-1:1]};
  assign last     = (cnt_q == CW'(WIDTH - 1));
  assign accept   = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    b_o_d   = b_o_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = b_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = sr_shift;
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          d_d     = sr_shift;
          b_o_d   = br_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      sr_q  <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      d_q   <= '0;
      b_o_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      sr_q  <= sr_d;
      br_q  <= br_d;
      cnt_q <= cnt_d;
      d_q   <= d_d;
      b_o_q <= b_o_d;
    end
  end

`ifdef SER_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand MSBs are kept because the shift registers lose them during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if ((state_q == RUN) && last) begin
        ovf_q <= (a_msb_q != b_msb_q) && (sr_shift[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign b_o  = b_o_q;

endmodule

// File: tb/tb_ser_sub_4.sv
// Self-checking bench for ser_sub_4 (WIDTH=4); the ovf expectation follows SER_SUB_OVF_EN.
module tb_ser_sub_4;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_i;
  logic         busy, done, b_o, ovf;
  logic [W-1:0] d;

  int checks = 0;
  int errors = 0;

  ser_sub_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_i(b_i),
    .busy(busy), .done(done), .d(d), .b_o(b_o), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, kept as a (W+1)-bit value {borrow, diff}.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int r;
    r = int'(x) - int'(y) - int'(bi);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
`ifdef SER_SUB_OVF_EN
    logic [W:0] r;
    r = ref_sub(x, y, bi);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  // Stimulus driver only: launches one op and reports latency and results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi,
                        output int lat, output logic [W-1:0] od, output logic ob,
                        output logic oo, output logic to);
    @(negedge clk);
    a = ta; b = tb_; b_i = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_i = 1'($urandom);
    lat = 0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    od = d; ob = b_o; oo = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, d, b_o, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%h b_o=%b ovf=%b, want all 0", busy, done, d, b_o, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int busy_cnt;
    int done_at;
    int done_cnt;
    @(negedge clk);
    a = 4'd7; b = 4'd3; b_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_at !== W) begin
      errors++;
      $display("FAIL basic_latency: done seen %0d edges after capture, want %0d", done_at, W);
    end
    checks++;
    if (busy_cnt !== W + 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d done cycles=%0d, want %0d and 1", busy_cnt, done_cnt, W + 1);
    end
    checks++;
    if (d !== 4'd4 || b_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got d=%h b_o=%b, want d=4 b_o=0", d, b_o);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] ta [2] = '{4'd3, 4'd0};
    logic [W-1:0] tb_[2] = '{4'd7, 4'd0};
    logic         tbi[2] = '{1'b0, 1'b1};
    logic [W:0]   want[2] = '{5'h1C, 5'h1F};
    int lat; logic [W-1:0] od; logic ob, oo, to;
    for (int k = 0; k < 2; k++) begin
      run_op(ta[k], tb_[k], tbi[k], lat, od, ob, oo, to);
      checks++;
      if (to || {ob, od} !== want[k]) begin
        errors++;
        $display("FAIL borrow_%0d: got {b_o,d}=%h timeout=%b, want %h", k, {ob, od}, to, want[k]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] od; logic ob, oo, to;
    logic [W-1:0] ra, rb; logic rbi;
    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      run_op(ra, rb, rbi, lat, od, ob, oo, to);
      checks++;
      if (to || lat != W || {ob, od} !== ref_sub(ra, rb, rbi) || oo !== ref_ovf(ra, rb, rbi)) begin
        errors++;
        $display("FAIL random a=%h b=%h bi=%b: got {b_o,d}=%h ovf=%b lat=%0d, want %h ovf=%b lat=%0d",
                 ra, rb, rbi, {ob, od}, oo, lat, ref_sub(ra, rb, rbi), ref_ovf(ra, rb, rbi), W);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] kv;
    logic [W:0] last_res;
    int k, cyc, last_done;
    k = 0; cyc = 0; last_done = 0; last_res = '0;
    @(negedge clk);
    kv = 9'd0;
    a = kv[8:5]; b = kv[4:1]; b_i = kv[0]; start = 1'b1;
    while (k < 512 && cyc < 512 * (W + 2) + 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        checks++;
        if ({b_o, d} !== ref_sub(kv[8:5], kv[4:1], kv[0]) || ovf !== ref_ovf(kv[8:5], kv[4:1], kv[0])) begin
          errors++;
          $display("FAIL b2b_result a=%h b=%h bi=%b: got {b_o,d}=%h ovf=%b, want %h ovf=%b",
                   kv[8:5], kv[4:1], kv[0], {b_o, d}, ovf, ref_sub(kv[8:5], kv[4:1], kv[0]),
                   ref_ovf(kv[8:5], kv[4:1], kv[0]));
        end
        if (k > 0) begin
          checks++;
          if (cyc - last_done != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing op %0d: got %0d cycles between dones, want %0d", k, cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        last_res = {b_o, d};
        k++;
        kv = 9'(k);
        if (k < 512) begin
          a = kv[8:5]; b = kv[4:1]; b_i = kv[0];
        end else begin
          start = 1'b0;
        end
      end else if (k > 0) begin
        checks++;
        if ({b_o, d} !== last_res) begin
          errors++;
          $display("FAIL b2b_hold: got {b_o,d}=%h between dones, want %h", {b_o, d}, last_res);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (k != 512) begin
      errors++;
      $display("FAIL b2b_count: got %0d completions, want 512", k);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_guard();
    int done_cnt;
    logic [W-1:0] od; logic ob;
    done_cnt = 0; od = '0; ob = 1'b0;
    @(negedge clk);
    a = 4'd13; b = 4'd6; b_i = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      start = 1'b1; a = W'($urandom); b = W'($urandom); b_i = 1'($urandom);
      @(posedge clk); #1;
      if (done) begin done_cnt++; od = d; ob = b_o; end
    end
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2 * (W + 2); i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL busy_guard_dones: got %0d done pulses, want 1", done_cnt);
    end
    checks++;
    if ({ob, od} !== 5'h06 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_guard_result: got {b_o,d}=%h busy=%b, want 06 busy=0", {ob, od}, busy);
    end
  endtask

  task automatic test_reset_midop();
    int done_cnt;
    int lat; logic [W-1:0] od; logic ob, oo, to;
    done_cnt = 0;
    @(negedge clk);
    a = 4'd2; b = 4'd9; b_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, b_o, ovf} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%b done=%b d=%h b_o=%b ovf=%b, want all 0", busy, done, d, b_o, ovf);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 * (W + 2); i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses busy=%b, want 0 and 0", done_cnt, busy);
    end
    run_op(4'd9, 4'd2, 1'b0, lat, od, ob, oo, to);
    checks++;
    if (to || od !== 4'd7 || ob !== 1'b0) begin
      errors++;
      $display("FAIL midop_after: got d=%h b_o=%b timeout=%b, want d=7 b_o=0", od, ob, to);
    end
  endtask

  task automatic test_ovf();
    logic [W-1:0] ta [3] = '{4'h8, 4'h7, 4'h5};
    logic [W-1:0] tb_[3] = '{4'h1, 4'hF, 4'h2};
    logic [W-1:0] wd [3] = '{4'h7, 4'h8, 4'h3};
`ifdef SER_SUB_OVF_EN
    logic         wo [3] = '{1'b1, 1'b1, 1'b0};
`else
    logic         wo [3] = '{1'b0, 1'b0, 1'b0};
`endif
    int lat; logic [W-1:0] od; logic ob, oo, to;
    for (int k = 0; k < 3; k++) begin
      run_op(ta[k], tb_[k], 1'b0, lat, od, ob, oo, to);
      checks++;
      if (to || od !== wd[k] || oo !== wo[k]) begin
        errors++;
        $display("FAIL ovf_%0d: got d=%h ovf=%b timeout=%b, want d=%h ovf=%b", k, od, oo, to, wd[k], wo[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_random();
    test_busy_guard();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
